// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 4-bit ALU: sweeps all operand pairs for
// opcodes 000..100, compares each result with a golden model and keeps a tally.
module alu_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [3:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [10:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [10:0] LAST_VEC    = 11'd1279;

  state_t      state_r;
  logic [3:0]  settle_r;
  logic [3:0]  expect_s;
  logic        mismatch_s;
  logic [10:0] vec_s;
  logic [10:0] next_vec_s;

  // Golden ALU model; results wrap modulo 16.
  function automatic logic [3:0] golden(input logic [2:0] sel,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    logic [3:0] r;
    case (sel)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // The vector index is exactly the concatenation {sel, A, B}.
  always_comb begin
    vec_s      = {alu_sel, alu_a, alu_b};
    next_vec_s = vec_s + 11'd1;
    expect_s   = golden(alu_sel, alu_a, alu_b);
    if (alu_result != expect_s) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Sweep sequencer with registered ALU drive and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      settle_r   <= 4'd0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_sel    <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 11'd0;
      first_fail <= 11'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r    <= DRIVE;
            settle_r   <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_sel    <= 3'b000;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 11'd0;
            first_fail <= 11'd0;
          end
        end
        DRIVE: begin
          if (settle_r == SETTLE_LAST) begin
            state_r <= CHECK;
          end else begin
            settle_r <= settle_r + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch_s) begin
            err_count <= err_count + 11'd1;
            if (err_count == 11'd0) begin
              first_fail <= vec_s;
            end
          end
          if (vec_s == LAST_VEC) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_count == 11'd0) && !mismatch_s;
          end else begin
            state_r                   <= DRIVE;
            settle_r                  <= 4'd0;
            {alu_sel, alu_a, alu_b}   <= next_vec_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: drives a behavioural ALU with selectable faults
// and checks sweep timing, tallies and reset behaviour on two parameterisations.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [3:0]  a1, b1, res1, a3, b3, res3;
  logic [2:0]  sel1, sel3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [10:0] err1, ff1, err3, ff3;
  int          fault = 0;   // 0 good, 1 SUB returns A+B, 2 bit0 stuck at 0
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_result(res1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  alu_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .alu_a(a3), .alu_b(b3), .alu_sel(sel3), .alu_result(res3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3)
  );

  function automatic logic [3:0] ref_alu(input logic [2:0] s, input logic [3:0] a,
                                         input logic [3:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      default: return 4'b0000;
    endcase
  endfunction

  // Stand-in ALU under test, with injectable faults on the first instance.
  always_comb begin
    res1 = ref_alu(sel1, a1, b1);
    if (fault == 1 && sel1 == 3'b001) res1 = a1 + b1;
    if (fault == 2) res1[0] = 1'b0;
    res3 = ref_alu(sel3, a3, b3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a sweep; k counts so that k means "value seen at edge E0+k".
  task automatic sweep(input bit use3, input string tag, input int exp_k,
                       input int extra_k, input int exp_err, input int exp_ff);
    int k;
    @(posedge clk); #1;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    k = 1;
    check({tag, "_e1_busy"}, use3 ? busy3 : busy1, 1);
    check({tag, "_e1_done"}, use3 ? done3 : done1, 0);
    check({tag, "_e1_err"},  use3 ? err3 : err1, 0);
    check({tag, "_e1_vec"},  use3 ? {sel3, a3, b3} : {sel1, a1, b1}, 0);
    while (!(use3 ? done3 : done1) && k < 12000) begin
      if (k == extra_k) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0; start3 = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (!use3 && k == 2) check({tag, "_v0_hold"}, {sel1, a1, b1}, 0);
      if (!use3 && k == 3) check({tag, "_v1"}, {sel1, a1, b1}, 1);
      if (use3 && k == 9) check({tag, "_v2"}, {sel3, a3, b3}, 2);
    end
    start1 = 1'b0; start3 = 1'b0;
    check({tag, "_done_k"}, k, exp_k);
    check({tag, "_busy"}, use3 ? busy3 : busy1, 0);
    check({tag, "_err"},  use3 ? err3 : err1, exp_err);
    check({tag, "_pass"}, use3 ? pass3 : pass1, (exp_err == 0) ? 1 : 0);
    check({tag, "_lastvec"}, use3 ? {sel3, a3, b3} : {sel1, a1, b1}, 32'h4FF);
    if (exp_err != 0) check({tag, "_ff"}, use3 ? ff3 : ff1, exp_ff);
  endtask

  initial begin
    #12;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_vec", {sel1, a1, b1}, 0);
    rst = 1'b0;

    fault = 0; sweep(1'b0, "good", 2561, -1, 0, 0);
    fault = 1; sweep(1'b0, "subflt", 2561, -1, 224, 257);
    fault = 2; sweep(1'b0, "bit0", 2561, -1, 640, 1);
    fault = 0; sweep(1'b0, "redo", 2561, -1, 0, 0);
    sweep(1'b1, "s3", 5121, 100, 0, 0);

    // Abort a faulty sweep with an asynchronous reset between clock edges.
    fault = 2;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (999) @(posedge clk);
    #3;
    check("pre_rst_err", (err1 != 11'd0) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy1, 0);
    check("arst_done", done1, 0);
    check("arst_pass", pass1, 0);
    check("arst_err", err1, 0);
    check("arst_ff", ff1, 0);
    check("arst_vec", {sel1, a1, b1}, 0);
    rst = 1'b0;
    fault = 0; sweep(1'b0, "post_rst", 2561, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
